serial_link_raw_calib_ctrl: RTL and testbench
=============================================

Name: serial_link_raw_calib_ctrl

Overview:
Calibration sequencer that drives the data link's raw-mode debug/config interface so a link check runs without software bit-banging. On start it does four things:
- takes the data link into raw mode and clears its FIFOs;
- pushes a deterministic training pattern onto all TX channels;
- reads the expected pattern back from each RX channel in turn, with a per-word timeout;
- reports a per-channel pass mask and returns the link to normal mode.

It sits between the register file / link bring-up logic and serial_link_data_link.

Parameters:
- NumChannels, serial_link_pkg::NumChannels, number of physical channels
- NumLanes, serial_link_pkg::NumLanes, lanes per channel; PhyW = 2*NumLanes bits per channel word
- phy_data_t, serial_link_pkg::phy_data_t, channel word type (PhyW bits)
- NumPatterns, 8, training words sent and expected per channel (>=1)
- PatternSeed, 'hA5, seed for the pattern (truncated/zero-extended to PhyW)
- TimeoutCycles, 1024, max wait cycles for one RX word on the selected channel (>=2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start request; ignored while busy_o=1
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when the sequence completes
- ch_ok_o  out  NumChannels  per-channel pass result, held until next start
- cfg_raw_mode_en_o  out  1  raw mode enable to data link
- cfg_flow_control_fifo_clear_o  out  1  flow-control FIFO flush
- cfg_raw_mode_in_ch_sel_o  out  max(1,clog2(NumChannels))  RX channel select
- cfg_raw_mode_in_data_i  in  PhyW  RX word of selected channel
- cfg_raw_mode_in_data_valid_i  in  NumChannels  RX valid per channel
- cfg_raw_mode_in_data_ready_o  out  1  RX read strobe
- cfg_raw_mode_out_ch_mask_o  out  NumChannels  TX channel mask
- cfg_raw_mode_out_data_o  out  PhyW  TX word
- cfg_raw_mode_out_data_valid_o  out  1  TX push request
- cfg_raw_mode_out_en_o  out  1  TX drain enable
- cfg_raw_mode_out_data_fifo_clear_o  out  1  raw TX FIFO flush
- cfg_raw_mode_out_data_fifo_is_full_i  in  1  raw TX FIFO full

Behaviour:
- Reset: state Idle. All outputs 0, including ch_ok_o. All counters 0.
- Pattern: word(i) = PatternSeed[PhyW-1:0] XOR i[PhyW-1:0], for i = 0..NumPatterns-1.
- States:
  - Idle: if start_i, go to Clear and clear ch_ok_o to 0.
  - Clear (1 cycle):
    - raw_en=1, out_fifo_clear=1, flow_control_fifo_clear=1, out_en=0.
    - Set word_idx=0, ch_idx=0, ok_q='1. Go to Fill.
  - Fill:
    - raw_en=1, out_en=1, ch_mask='1, out_data=word(word_idx).
    - out_data_valid = ~fifo_is_full_i. The data link pushes only on valid&~full, so word_idx advances only when ~full.
    - After the last word is pushed, set word_idx=0, timeout=0 and go to Recv.
  - Recv:
    - raw_en=1, out_en=1, in_ch_sel=ch_idx.
    - in_data_ready = valid_i[ch_idx]; the word is sampled in the same cycle.
    - On a read: compare the word with word(word_idx); on mismatch clear ok_q[ch_idx] (sticky). Then word_idx++ and timeout=0.
    - Mismatch does not stop reading; the remaining words are still consumed, so the stream stays aligned for the next channel.
    - No valid: timeout++. At TimeoutCycles-1, clear ok_q[ch_idx] and end this channel.
    - Channel end (last word read or timeout): word_idx=0, timeout=0, ch_idx++. After channel NumChannels-1, go to Finish.
  - Finish (1 cycle):
    - raw_en=0, out_en=0, flow_control_fifo_clear=1.
    - ch_ok_o <= ok_q, done_o=1. Go to Idle.
- busy_o = (state != Idle).
- ch_ok_o is updated only in Finish, and cleared on an accepted start.
- start_i while busy is ignored. start_i coincident with done_o is ignored (busy still 1 in that cycle).
- fifo_is_full_i held at 1 keeps the block stalled in Fill indefinitely; there is no timeout in Fill.
- Asynchronous reset mid-sequence returns to Idle immediately. raw_en drops combinationally, with no done pulse.
- Counter widths:
  - word_idx: clog2(NumPatterns+1)
  - ch_idx: clog2(NumChannels+1)
  - timeout: clog2(TimeoutCycles)
- Counters never wrap in legal operation.

Decomposition:
- serial_link_pkg gains:
  - calib_state_e {CalibIdle, CalibClear, CalibFill, CalibRecv, CalibFinish}
  - the default constants CalibNumPatterns=8, CalibPatternSeed='hA5, CalibTimeoutCycles=1024
- Single module, no sub-module. The pattern generator is an inline function word(i) within the module.

Test Plan:
All scenarios use NumChannels=2, NumLanes=4 (PhyW=8), NumPatterns=4, PatternSeed='hA5, TimeoutCycles=16.
- Happy path: pulse start; model always not full; RX model returns A5,A4,A7,A6 on ch0 then ch1 → TX pushes A5,A4,A7,A6 with mask 2'b11; ch_ok_o=2'b11; done_o pulses once; raw_en low after Finish.
- Mismatch: ch1 returns A5,A4,00,A6 → all 4 words consumed from ch1; ch_ok_o=2'b01.
- Timeout: ch0 valid never rises → ch0 fails after 16 cycles; ch1 good → ch_ok_o=2'b10; total Recv cycles for ch0 = 16.
- Backpressure: full_i held 1 for 10 cycles during Fill → no valid pushes while full; exactly 4 pushes overall with correct ordered data.
- Start while busy and reset: start_i pulsed mid-Recv → ignored, single done; second run: assert rst_ni low mid-Fill → all outputs 0, busy_o=0, ch_ok_o=0, no done_o.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared serial link parameters, channel word type and raw-mode calibration sequencer states.
package serial_link_pkg;

    localparam int unsigned NumChannels = 2;
    localparam int unsigned NumLanes    = 4;

    typedef logic [2*NumLanes-1:0] phy_data_t;

    localparam int unsigned CalibNumPatterns   = 8;
    localparam int unsigned CalibPatternSeed   = 'hA5;
    localparam int unsigned CalibTimeoutCycles = 1024;

    typedef enum logic [2:0] {
        CalibIdle   = 3'd0,
        CalibClear  = 3'd1,
        CalibFill   = 3'd2,
        CalibRecv   = 3'd3,
        CalibFinish = 3'd4
    } calib_state_e;

endpackage

// File: rtl/serial_link_raw_calib_ctrl.sv
// Raw-mode link calibration: flushes the data link, pushes a training pattern to all TX
// channels, reads it back per RX channel with a per-word timeout and reports a pass mask.
module serial_link_raw_calib_ctrl
    import serial_link_pkg::*;
#(
    parameter int unsigned  NumChannels   = serial_link_pkg::NumChannels,
    parameter int unsigned  NumLanes      = serial_link_pkg::NumLanes,
    parameter type          phy_data_t    = serial_link_pkg::phy_data_t,
    parameter int unsigned  NumPatterns   = serial_link_pkg::CalibNumPatterns,
    parameter int unsigned  PatternSeed   = serial_link_pkg::CalibPatternSeed,
    parameter int unsigned  TimeoutCycles = serial_link_pkg::CalibTimeoutCycles,
    localparam int unsigned ChSelW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NumChannels-1:0] ch_ok_o,
    output logic                   cfg_raw_mode_en_o,
    output logic                   cfg_flow_control_fifo_clear_o,
    output logic [ChSelW-1:0]      cfg_raw_mode_in_ch_sel_o,
    input  phy_data_t              cfg_raw_mode_in_data_i,
    input  logic [NumChannels-1:0] cfg_raw_mode_in_data_valid_i,
    output logic                   cfg_raw_mode_in_data_ready_o,
    output logic [NumChannels-1:0] cfg_raw_mode_out_ch_mask_o,
    output phy_data_t              cfg_raw_mode_out_data_o,
    output logic                   cfg_raw_mode_out_data_valid_o,
    output logic                   cfg_raw_mode_out_en_o,
    output logic                   cfg_raw_mode_out_data_fifo_clear_o,
    input  logic                   cfg_raw_mode_out_data_fifo_is_full_i
);

    localparam int unsigned PhyW     = 2 * NumLanes;
    localparam int unsigned WordW    = $clog2(NumPatterns + 1);
    localparam int unsigned ChIdxW   = $clog2(NumChannels + 1);
    localparam int unsigned TimeoutW = $clog2(TimeoutCycles);

    calib_state_e          state_q, state_d;
    logic [WordW-1:0]      word_idx_q, word_idx_d;
    logic [ChIdxW-1:0]     ch_idx_q, ch_idx_d;
    logic [TimeoutW-1:0]   timeout_q, timeout_d;
    logic [NumChannels-1:0] ok_q, ok_d;
    logic [NumChannels-1:0] ch_ok_q, ch_ok_d;
    logic [ChSelW-1:0]     ch_sel;
    logic                  ch_end;

    // Training pattern: seed XOR word index, both taken at channel word width.
    function automatic phy_data_t word(input logic [WordW-1:0] idx);
        return phy_data_t'(PhyW'(PatternSeed) ^ PhyW'(idx));
    endfunction

    assign ch_sel  = ChSelW'(ch_idx_q);
    assign ch_ok_o = ch_ok_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CalibIdle;
            word_idx_q <= '0;
            ch_idx_q   <= '0;
            timeout_q  <= '0;
            ok_q       <= '0;
            ch_ok_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            ch_idx_q   <= ch_idx_d;
            timeout_q  <= timeout_d;
            ok_q       <= ok_d;
            ch_ok_q    <= ch_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        ch_idx_d   = ch_idx_q;
        timeout_d  = timeout_q;
        ok_d       = ok_q;
        ch_ok_d    = ch_ok_q;
        ch_end     = 1'b0;

        busy_o                             = (state_q != CalibIdle);
        done_o                             = 1'b0;
        cfg_raw_mode_en_o                  = 1'b0;
        cfg_flow_control_fifo_clear_o      = 1'b0;
        cfg_raw_mode_in_ch_sel_o           = '0;
        cfg_raw_mode_in_data_ready_o       = 1'b0;
        cfg_raw_mode_out_ch_mask_o         = '0;
        cfg_raw_mode_out_data_o            = '0;
        cfg_raw_mode_out_data_valid_o      = 1'b0;
        cfg_raw_mode_out_en_o              = 1'b0;
        cfg_raw_mode_out_data_fifo_clear_o = 1'b0;

        unique case (state_q)
            CalibIdle: begin
                if (start_i) begin
                    state_d = CalibClear;
                    ch_ok_d = '0;
                end
            end
            CalibClear: begin
                cfg_raw_mode_en_o                  = 1'b1;
                cfg_raw_mode_out_data_fifo_clear_o = 1'b1;
                cfg_flow_control_fifo_clear_o      = 1'b1;
                word_idx_d = '0;
                ch_idx_d   = '0;
                ok_d       = '1;
                state_d    = CalibFill;
            end
            CalibFill: begin
                cfg_raw_mode_en_o             = 1'b1;
                cfg_raw_mode_out_en_o         = 1'b1;
                cfg_raw_mode_out_ch_mask_o    = '1;
                cfg_raw_mode_out_data_o       = word(word_idx_q);
                cfg_raw_mode_out_data_valid_o = ~cfg_raw_mode_out_data_fifo_is_full_i;
                // The data link only accepts a push while its raw TX FIFO has room.
                if (!cfg_raw_mode_out_data_fifo_is_full_i) begin
                    if (word_idx_q == WordW'(NumPatterns - 1)) begin
                        word_idx_d = '0;
                        timeout_d  = '0;
                        state_d    = CalibRecv;
                    end else begin
                        word_idx_d = word_idx_q + WordW'(1);
                    end
                end
            end
            CalibRecv: begin
                cfg_raw_mode_en_o            = 1'b1;
                cfg_raw_mode_out_en_o        = 1'b1;
                cfg_raw_mode_in_ch_sel_o     = ch_sel;
                cfg_raw_mode_in_data_ready_o = cfg_raw_mode_in_data_valid_i[ch_sel];
                // Mismatches are sticky but reading continues so the stream stays aligned.
                if (cfg_raw_mode_in_data_valid_i[ch_sel]) begin
                    if (cfg_raw_mode_in_data_i != word(word_idx_q)) begin
                        ok_d[ch_sel] = 1'b0;
                    end
                    timeout_d = '0;
                    if (word_idx_q == WordW'(NumPatterns - 1)) begin
                        ch_end = 1'b1;
                    end else begin
                        word_idx_d = word_idx_q + WordW'(1);
                    end
                end else if (timeout_q == TimeoutW'(TimeoutCycles - 1)) begin
                    ok_d[ch_sel] = 1'b0;
                    ch_end       = 1'b1;
                end else begin
                    timeout_d = timeout_q + TimeoutW'(1);
                end
                if (ch_end) begin
                    word_idx_d = '0;
                    timeout_d  = '0;
                    ch_idx_d   = ch_idx_q + ChIdxW'(1);
                    if (ch_idx_q == ChIdxW'(NumChannels - 1)) begin
                        state_d = CalibFinish;
                    end
                end
            end
            CalibFinish: begin
                cfg_flow_control_fifo_clear_o = 1'b1;
                ch_ok_d = ok_q;
                done_o  = 1'b1;
                state_d = CalibIdle;
            end
            default: begin
                state_d = CalibIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_link_raw_calib_ctrl.sv
// Scoreboarded random bench for the raw-mode calibration sequencer with a pattern-level
// reference model of the expected TX stream and per-channel pass mask.
module tb_serial_link_raw_calib_ctrl;

    localparam int unsigned NCH  = 2;
    localparam int unsigned NPAT = 4;
    localparam int unsigned SEED = 'hA5;
    localparam int unsigned TMO  = 16;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done;
    logic [1:0] ch_ok;
    logic       raw_en, fc_clr;
    logic       ch_sel;
    logic [7:0] in_data;
    logic [1:0] in_valid;
    logic       in_ready;
    logic [1:0] out_mask;
    logic [7:0] out_data;
    logic       out_valid, out_en, out_fifo_clr, full;

    serial_link_raw_calib_ctrl #(
        .NumChannels  (NCH),
        .NumLanes     (4),
        .phy_data_t   (logic [7:0]),
        .NumPatterns  (NPAT),
        .PatternSeed  (SEED),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i                               (clk),
        .rst_ni                              (rst_n),
        .start_i                             (start),
        .busy_o                              (busy),
        .done_o                              (done),
        .ch_ok_o                             (ch_ok),
        .cfg_raw_mode_en_o                   (raw_en),
        .cfg_flow_control_fifo_clear_o       (fc_clr),
        .cfg_raw_mode_in_ch_sel_o            (ch_sel),
        .cfg_raw_mode_in_data_i              (in_data),
        .cfg_raw_mode_in_data_valid_i        (in_valid),
        .cfg_raw_mode_in_data_ready_o        (in_ready),
        .cfg_raw_mode_out_ch_mask_o          (out_mask),
        .cfg_raw_mode_out_data_o             (out_data),
        .cfg_raw_mode_out_data_valid_o       (out_valid),
        .cfg_raw_mode_out_en_o               (out_en),
        .cfg_raw_mode_out_data_fifo_clear_o  (out_fifo_clr),
        .cfg_raw_mode_out_data_fifo_is_full_i(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_exp[$];
    logic [1:0] ok_exp[$];
    logic [7:0] rx_words[2][4];
    int         rx_ptr[2];
    int         rx_dly[2];
    bit         dead[2];
    int         full_hold;
    bit         rand_full;
    int         done_cnt, push_cnt, recv0_cycles;
    bit         ok_pending;
    logic [1:0] ok_pending_val;

    function automatic logic [7:0] pat(input int i);
        return 8'(SEED) ^ 8'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Link-side model: TX FIFO fullness and per-channel RX word streams.
    always begin
        @(negedge clk);
        if (full_hold > 0 && out_mask == 2'b11) begin
            full = 1'b1;
            full_hold--;
        end else begin
            full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            in_valid[c] = !dead[c] && rx_ptr[c] < NPAT && rx_dly[c] == 0;
            if (rx_dly[c] > 0) rx_dly[c]--;
        end
        if (rx_ptr[int'(ch_sel)] < NPAT) in_data = rx_words[int'(ch_sel)][rx_ptr[int'(ch_sel)]];
        else in_data = 8'h00;
        #1;
        if (in_ready) begin
            rx_ptr[int'(ch_sel)]++;
            rx_dly[int'(ch_sel)] = $urandom_range(0, 6);
        end
    end

    // Monitor: pops expectations whenever the DUT pushes a TX word or signals done.
    always begin
        @(negedge clk);
        #2;
        if (ok_pending) begin
            chk("ch_ok_after_done", ch_ok, ok_pending_val);
            chk("busy_after_done", busy, 0);
            chk("raw_en_after_done", raw_en, 0);
            chk("done_single_cycle", done, 0);
            ok_pending = 1'b0;
        end
        if (rst_n) begin
            if (out_mask == 2'b11 && full) chk("valid_while_full", out_valid, 0);
            if (out_valid && !full) begin
                push_cnt++;
                if (tx_exp.size() == 0) note_fail("unexpected_tx_push");
                else begin
                    chk("tx_data", out_data, tx_exp.pop_front());
                    chk("tx_mask", out_mask, 2'b11);
                end
            end
            if (raw_en && out_en && out_mask == 2'b00 && ch_sel == 1'b0) recv0_cycles++;
            if (done) begin
                done_cnt++;
                if (ok_exp.size() == 0) note_fail("unexpected_done");
                else begin
                    ok_pending     = 1'b1;
                    ok_pending_val = ok_exp.pop_front();
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ch_ok"}, ch_ok, 0);
        chk({tag, "_raw_en"}, raw_en, 0);
        chk({tag, "_fc_clr"}, fc_clr, 0);
        chk({tag, "_ch_sel"}, ch_sel, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_mask"}, out_mask, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_en"}, out_en, 0);
        chk({tag, "_out_fifo_clr"}, out_fifo_clr, 0);
    endtask

    task automatic set_good();
        for (int c = 0; c < 2; c++) begin
            dead[c] = 1'b0;
            for (int i = 0; i < NPAT; i++) rx_words[c][i] = pat(i);
        end
    endtask

    // Reference model: a channel passes iff it delivers every word and each equals the pattern.
    task automatic launch();
        logic [1:0] exp_ok;
        for (int i = 0; i < NPAT; i++) tx_exp.push_back(pat(i));
        for (int c = 0; c < 2; c++) begin
            bit good;
            good = !dead[c];
            for (int i = 0; i < NPAT; i++) if (rx_words[c][i] != pat(i)) good = 1'b0;
            exp_ok[c] = good;
            rx_ptr[c] = 0;
            rx_dly[c] = $urandom_range(0, 6);
        end
        ok_exp.push_back(exp_ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) note_fail({tag, "_done_timeout"});
        repeat (3) @(negedge clk);
        chk({tag, "_tx_all_pushed"}, tx_exp.size(), 0);
        for (int c = 0; c < 2; c++) if (!dead[c]) chk({tag, "_rx_consumed"}, rx_ptr[c], NPAT);
    endtask

    initial begin
        int p0;
        int d0;
        int n;
        start     = 1'b0;
        full      = 1'b0;
        in_valid  = 2'b00;
        in_data   = 8'h00;
        full_hold = 0;
        rand_full = 1'b0;
        done_cnt  = 0;
        push_cnt  = 0;
        ok_pending = 1'b0;
        rx_ptr    = '{NPAT, NPAT};
        rx_dly    = '{0, 0};
        dead      = '{1'b0, 1'b0};
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_quiet("in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #3 check_quiet("after_reset");

        // Happy path
        set_good();
        p0 = push_cnt;
        launch();
        wait_done("happy", 300);
        chk("happy_push_count", push_cnt - p0, NPAT);

        // Mismatch on ch1 word 2
        set_good();
        rx_words[1][2] = 8'h00;
        launch();
        wait_done("mismatch", 300);
        chk("mismatch_ch1_consumed", rx_ptr[1], NPAT);

        // Timeout on ch0
        set_good();
        dead[0] = 1'b1;
        recv0_cycles = 0;
        launch();
        wait_done("timeout", 300);
        chk("timeout_recv_cycles", recv0_cycles, TMO);
        chk("timeout_ch0_untouched", rx_ptr[0], 0);

        // Backpressure during Fill
        set_good();
        full_hold = 10;
        p0 = push_cnt;
        launch();
        wait_done("backpressure", 300);
        chk("bp_push_count", push_cnt - p0, NPAT);
        chk("bp_full_cycles_used", full_hold, 0);

        // Randomised runs
        rand_full = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_good();
            for (int c = 0; c < 2; c++) begin
                dead[c] = ($urandom_range(0, 5) == 0);
                for (int i = 0; i < NPAT; i++)
                    if ($urandom_range(0, 9) == 0) rx_words[c][i] = 8'($urandom);
            end
            p0 = push_cnt;
            launch();
            wait_done("random", 400);
            chk("random_push_count", push_cnt - p0, NPAT);
        end
        rand_full = 1'b0;

        // Start while busy (mid-Recv) is ignored
        set_good();
        d0 = done_cnt;
        launch();
        n = 0;
        while (!(raw_en && out_en && out_mask == 2'b00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) note_fail("busy_start_recv_not_reached");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 300);
        repeat (20) @(negedge clk);
        chk("busy_start_single_done", done_cnt - d0, 1);
        chk("busy_start_idle", busy, 0);

        // Asynchronous reset mid-Fill
        set_good();
        full_hold = 1000;
        d0 = done_cnt;
        launch();
        n = 0;
        while (out_mask != 2'b11 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) note_fail("reset_fill_not_reached");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check_quiet("mid_fill_reset");
        tx_exp.delete();
        ok_exp.delete();
        full_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_busy_low", busy, 0);
        chk("reset_raw_en_low", raw_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
